shift_counter: RTL and testbench



---
 rtl/shift_counter.sv | 62 ++++++
 tb/tb_shift_counter.sv | 83 ++++++++
 2 files changed

// File: rtl/shift_counter.sv
// One-hot bounce counter: a single 1 walks from LSB to MSB and back, each endpoint held one clock.
// Optional build macro SHIFT_COUNTER_ONEHOT_CHECK_EN adds recovery from non-one-hot states.
module shift_counter #(
   parameter int WIDTH = 8
) (
   output logic [WIDTH-1:0] cout,
   input  logic             clk,
   input  logic             reset
);

   logic             dir;
   logic [WIDTH-1:0] cout_nxt;
   logic             dir_nxt;
   logic             bad;

`ifdef SHIFT_COUNTER_ONEHOT_CHECK_EN
   // x & (x-1) clears the lowest set bit; zero result with nonzero x means exactly one bit set
   assign bad = (cout == '0) || ((cout & (cout - WIDTH'(1))) != '0);
`else
   assign bad = 1'b0;
`endif

   always_comb begin
      cout_nxt = cout;
      dir_nxt  = dir;
      if (bad) begin
         cout_nxt = WIDTH'(1);
         dir_nxt  = 1'b0;
      end else if (!dir) begin
         // turn around when the next left shift would fall off the MSB
         if (cout[WIDTH-1]) begin
            dir_nxt  = 1'b1;
            cout_nxt = cout >> 1;
         end else begin
            cout_nxt = cout << 1;
         end
      end else begin
         if (cout[0]) begin
            dir_nxt  = 1'b0;
            cout_nxt = cout << 1;
         end else begin
            cout_nxt = cout >> 1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cout <= WIDTH'(1);
         dir  <= 1'b0;
      end else begin
         cout <= cout_nxt;
         dir  <= dir_nxt;
`ifdef SHIFT_COUNTER_ONEHOT_CHECK_EN
`ifndef SYNTHESIS
         if (bad) $display("shift_counter warning: non-one-hot cout %b at %0t, recovering", cout, $time);
`endif
`endif
      end
   end

endmodule

// File: tb/tb_shift_counter.sv
// Directed bench for shift_counter: async reset, full bounce period, mid-run reset, illegal-state handling.
module tb_shift_counter;

   logic       clk;
   logic       reset;
   logic [7:0] cout;

   int n_cmp;
   int n_bad;

   shift_counter #(.WIDTH(8)) dut (
      .cout  (cout),
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", tag, got, exp);
      end
   endtask

   task automatic step_chk(input string tag, input logic [7:0] exp);
      @(posedge clk);
      #1;
      chk(tag, cout, exp);
   endtask

   logic [7:0] period [15];
   logic [7:0] to_mid [8];

   initial begin
      period = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      to_mid = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;

      // reset pulse between edges at 35 and 45: value must appear without a clock
      #40 reset = 1'b1;
      #2  chk("async_reset", cout, 8'h01);
      #2  reset = 1'b0;

      for (int i = 0; i < 15; i++) step_chk($sformatf("period_%0d", i + 1), period[i]);

      // walk on until 0010_0000 on the way down
      for (int i = 0; i < 8; i++) step_chk($sformatf("to_mid_%0d", i), to_mid[i]);

      #3 reset = 1'b1;
      #1 chk("mid_reset", cout, 8'h01);
      for (int i = 0; i < 3; i++) step_chk($sformatf("reset_hold_%0d", i), 8'h01);
      #3 reset = 1'b0;
      step_chk("post_reset_1", 8'h02);
      step_chk("post_reset_2", 8'h04);

`ifdef SHIFT_COUNTER_ONEHOT_CHECK_EN
      #3 force dut.cout = 8'h06;
      #1 release dut.cout;
      step_chk("illegal_recover", 8'h01);
      step_chk("illegal_then_left", 8'h02);
`else
      #3 force dut.cout = 8'h00;
      #1 release dut.cout;
      step_chk("zero_stays_1", 8'h00);
      step_chk("zero_stays_2", 8'h00);
`endif

      #3 reset = 1'b1;
      #1 chk("final_reset", cout, 8'h01);
      #3 reset = 1'b0;
      step_chk("final_step", 8'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
